// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N writeback
// requesters, with a pending-write scoreboard used by decode for hazard stalls.
module regfile_wb_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N*AW-1:0]   req_rd,
  input  logic [N*DW-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_rd,
  output logic [(1<<AW)-1:0] busy,
  output logic              RegWrite,
  output logic [AW-1:0]     wr_rd,
  output logic [DW-1:0]     wr_data
);

  localparam int unsigned NR = 1 << AW;
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NR-1:0] busy_q, busy_d;
  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] wr_rd_q, wr_rd_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] scan_idx;
  logic [AW-1:0] gnt_rd;
  logic [DW-1:0] gnt_data;

  // First valid requester at or after the round-robin pointer wins; reset masks all grants.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(N); k++) begin
      scan_idx = PW'((int'(rr_ptr_q) + k) % int'(N));
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    if (rst) begin
      gnt_found = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign gnt_rd   = req_rd[int'(gnt_idx)*int'(AW) +: AW];
  assign gnt_data = req_data[int'(gnt_idx)*int'(DW) +: DW];

  // Next state: pointer advance, write-port capture, scoreboard clear then set (set wins).
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    reg_write_d = 1'b0;
    wr_rd_d     = wr_rd_q;
    wr_data_d   = wr_data_q;
    if (gnt_found) begin
      rr_ptr_d       = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
      reg_write_d    = (gnt_rd != '0);
      wr_rd_d        = gnt_rd;
      wr_data_d      = gnt_data;
      busy_d[gnt_rd] = 1'b0;
    end
    if (rsv_valid && (rsv_rd != '0)) begin
      busy_d[rsv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      busy_q      <= '0;
      reg_write_q <= 1'b0;
      wr_rd_q     <= '0;
      wr_data_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      reg_write_q <= reg_write_d;
      wr_rd_q     <= wr_rd_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy     = busy_q;
  assign RegWrite = reg_write_q;
  assign wr_rd    = wr_rd_q;
  assign wr_data  = wr_data_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file among N writeback requesters: ALU, load unit, and multiply/divide unit.
- Uses round-robin arbitration with a valid/ready handshake on each requester.
- Keeps a 32-bit scoreboard of destination registers that have a writeback pending; decode uses it for hazard stalls.
- Sits between the execute/memory stages and the register file's RegWrite/rd/write_data inputs.

Parameters:
- N, 3, number of writeback requesters (2..8).
- DW, 32, data width.
- AW, 5, register address width (2**AW registers).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  requester i holds a writeback.
- req_rd  in  N*AW  destination of requester i, packed as slice [i*AW +: AW].
- req_data  in  N*DW  data of requester i, packed as slice [i*DW +: DW].
- req_ready  out  N  grant; a transfer happens when req_valid[i] & req_ready[i].
- rsv_valid  in  1  decode reserves a destination register this cycle.
- rsv_rd  in  AW  register being reserved.
- busy  out  2**AW  scoreboard; bit r=1 means a writeback to r is pending.
- RegWrite  out  1  register-file write enable, registered.
- wr_rd  out  AW  register-file write address, registered.
- wr_data  out  DW  register-file write data, registered.

Behaviour:
- Reset: when rst=1 at a rising edge:
  - RegWrite=0, wr_rd=0, wr_data=0, busy=0, round-robin pointer rr_ptr=0.
  - req_ready is all-zero during any cycle in which rst=1.
  - Reset takes effect mid-operation with no drain: pending reservations and any in-flight output are discarded.
- Arbitration (combinational within the cycle):
  - Scan i = rr_ptr, rr_ptr+1, … mod N.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0. At most one grant per cycle.
  - req_ready never depends on its own requester's data, only on req_valid.
  - A requester must hold valid, rd and data stable until granted (bench checks this as an assumption).
- Pointer update: on a grant to index g, rr_ptr <= (g+1) mod N. With no grant, rr_ptr holds.
- Fairness: a continuously valid requester is granted within N cycles.
- Write output, one-cycle latency:
  - On a grant in cycle t, at edge t+1: RegWrite=1, wr_rd=req_rd[g], wr_data=req_data[g].
  - With no grant: RegWrite=0; wr_rd and wr_data hold their previous values.
  - The register file samples on the falling edge, so outputs are stable for half a cycle beforehand.
- Register 0:
  - A granted request with rd=0 is still handshaken (consumed) and advances rr_ptr.
  - It produces RegWrite=0, so r0 is never written.
  - Reservation of rd=0 is ignored; busy[0] is always 0.
- Scoreboard, per edge:
  - busy[r] is set when rsv_valid & rsv_rd=r & r≠0.
  - busy[r] is cleared when a grant occurs with req_rd[g]=r. The clear happens at the same edge the output is registered, not one later.
  - Same-cycle set and clear of the same r: the set wins and busy[r] stays 1, since it is a new reservation.
  - Set and clear of different registers in the same cycle both apply.
  - No counting: multiple outstanding writes to the same r are not tracked. Decode must not reserve an already-busy register (assertion in bench).
- Back-to-back: a grant is possible every cycle, giving one register-file write per cycle at full throughput.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release, keep all valids 0 for 5 cycles → RegWrite=0, busy=0, req_ready=000 throughout.
- Single write: req_valid=001, req_rd[0]=5, req_data[0]=32'hDEADBEEF → req_ready=001 that cycle; next cycle RegWrite=1, wr_rd=5, wr_data=DEADBEEF; following cycle RegWrite=0.
- Round-robin: req_valid=111 held, rd={3,2,1} for i={2,1,0}, all reissued after each grant → grants 0,1,2,0,1,2; wr_rd sequence 1,2,3,1,2,3; no cycle without a write.
- Scoreboard: reserve r7 at cycle 0 → busy[7]=1 from cycle 1; requester 1 writes r7 granted at cycle 4 → busy[7]=0 and RegWrite=1, wr_rd=7 at the same edge. Separately, reserve r9 in the same cycle a write to r9 is granted → busy[9] stays 1.
- r0 handling: grant request with rd=0, data=32'h1 → req_ready pulses, RegWrite stays 0, rr_ptr advances to 1. Reserve r0 → busy[0]=0.
- Reset mid-operation: busy[12]=1 and req_valid=010 pending; assert rst for one cycle → next cycle busy=0, RegWrite=0, rr_ptr=0; after release, requester 1 is granted.
